// File: rtl/uart_cmd_pkg.sv
// Shared command dictionary for the UART command parser and transmitter.
// Strings are left-justified: character 0 sits in the most significant byte.
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        CMD_QSTICK  = 4'd0,
        CMD_GOLDEN  = 4'd1,
        CMD_SODAPOP = 4'd2,
        CMD_PAUSE   = 4'd3,
        CMD_RESTART = 4'd4,
        CMD_RESET   = 4'd5,
        CMD_BAD     = 4'd6,
        CMD_GOOD    = 4'd7,
        CMD_PERFECT = 4'd8,
        CMD_NONE    = 4'hF
    } cmd_e;

    localparam int CMD_NUM    = 9;
    localparam int CMD_MAXLEN = 8;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef logic [CMD_MAXLEN*8-1:0] cmd_str_t;

    // Listed from the highest command index down to index 0.
    localparam cmd_str_t [CMD_NUM-1:0] CMD_STR = {
        {"PERFECT", 8'h00},
        {"GOOD",    32'h0},
        {"BAD",     40'h0},
        {"reset",   24'h0},
        {"restart", 8'h00},
        {"pause",   24'h0},
        {"sodapop", 8'h00},
        {"golden",  16'h0},
        {"qstick",  16'h0}
    };

    localparam logic [CMD_NUM-1:0][3:0] CMD_LEN = {
        4'd7, 4'd4, 4'd3, 4'd5, 4'd7, 4'd5, 4'd7, 4'd6, 4'd6
    };

    function automatic logic [7:0] cmd_char(input cmd_str_t s, input int pos);
        return s[(CMD_MAXLEN-1-pos)*8 +: 8];
    endfunction

endpackage

// File: rtl/uart_cmd_rom.sv
// Combinational lookup of one command string: byte at a character index and
// the command length. Out-of-range indices return zero.
module uart_cmd_rom
    import uart_cmd_pkg::*;
(
    input  logic [3:0] cmd_idx,
    input  logic [3:0] char_idx,
    output logic [7:0] char_byte,
    output logic [3:0] cmd_len
);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        char_byte = 8'h00;
        cmd_len   = 4'd0;
        if (int'(cmd_idx) < CMD_NUM) begin
            cmd_len = CMD_LEN[cmd_idx];
            if (int'(char_idx) < CMD_MAXLEN) begin
                char_byte = cmd_char(CMD_STR[cmd_idx], int'(char_idx));
            end
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Line-oriented command recogniser fed from a show-ahead UART RX FIFO.
// All nine candidates are compared in parallel; a mask narrows them per character.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN         = 8,
    parameter int POP_EVERY_CYCLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_empty,
    output logic       rx_pop,
    output logic       cmd_valid,
    output logic [3:0] cmd_code,
    output logic       cmd_err,
    output logic       busy
);

    localparam int                 LEN_W    = $clog2(MAX_LEN + 1);
    localparam logic [CMD_NUM-1:0] MASK_ALL = '1;

    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, EMIT} state_e;

    state_e             state;
    logic [LEN_W-1:0]   length;
    logic [CMD_NUM-1:0] mask;
    logic [CMD_NUM-1:0] mask_next;
    logic               gap;

    logic [3:0] rom_pos;
    logic [7:0] rom_byte [CMD_NUM];
    logic [3:0] rom_len  [CMD_NUM];

    logic [3:0] hit_code;
    logic       hit_len_ok;
    logic       hit;
    logic       is_lf;
    logic       is_cr;
    logic       char_accept;

    // Positions past the longest command read as zero and drop every candidate.
    always_comb begin
        rom_pos = 4'(CMD_MAXLEN);
        if (int'(length) < CMD_MAXLEN) begin
            rom_pos = 4'(length);
        end
    end

    for (genvar g = 0; g < CMD_NUM; g++) begin : g_rom
        uart_cmd_rom u_rom (
            .cmd_idx   (4'(g)),
            .char_idx  (rom_pos),
            .char_byte (rom_byte[g]),
            .cmd_len   (rom_len[g])
        );
    end

    always_comb begin
        mask_next = mask;
        for (int k = 0; k < CMD_NUM; k++) begin
            if (int'(rom_len[k]) <= int'(length) || rom_byte[k] != rx_data) begin
                mask_next[k] = 1'b0;
            end
        end
    end

    always_comb begin
        hit_code   = CMD_NONE;
        hit_len_ok = 1'b0;
        for (int k = 0; k < CMD_NUM; k++) begin
            if (mask[k]) begin
                hit_code   = 4'(k);
                hit_len_ok = (int'(rom_len[k]) == int'(length));
            end
        end
        hit = $onehot(mask) && hit_len_ok;
    end

    // The pop strobe follows the FIFO flag directly so a byte is taken the same cycle it shows.
    assign rx_pop      = reset && !rx_empty && (state != EMIT) && !gap;
    assign is_lf       = (rx_data == ASCII_LF);
    assign is_cr       = (rx_data == ASCII_CR);
    assign char_accept = rx_pop && !is_cr;
    assign busy        = (length != '0) || (state == DISCARD);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            length    <= '0;
            mask      <= MASK_ALL;
            gap       <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_code  <= CMD_NONE;
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            gap       <= (POP_EVERY_CYCLE == 0) && rx_pop;

            case (state)
                IDLE: begin
                    if (char_accept) begin
                        if (is_lf) begin
                            state   <= EMIT;
                            cmd_err <= 1'b1;
                        end else begin
                            state  <= COLLECT;
                            length <= LEN_W'(1);
                            mask   <= mask_next;
                        end
                    end
                end

                COLLECT: begin
                    if (char_accept) begin
                        if (is_lf) begin
                            state <= EMIT;
                            if (hit) begin
                                cmd_valid <= 1'b1;
                                cmd_code  <= hit_code;
                            end else begin
                                cmd_err <= 1'b1;
                            end
                        end else if (int'(length) >= MAX_LEN) begin
                            state <= DISCARD;
                        end else begin
                            length <= length + 1'b1;
                            mask   <= mask_next;
                        end
                    end
                end

                DISCARD: begin
                    if (char_accept && is_lf) begin
                        state   <= EMIT;
                        cmd_err <= 1'b1;
                    end
                end

                EMIT: begin
                    state  <= IDLE;
                    length <= '0;
                    mask   <= MASK_ALL;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, giving the maximum command characters before the terminator.
REQ-002 SHALL have parameter POP_EVERY_CYCLE, default 1; when set to 0, a one-cycle gap is inserted between pops.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  8  head byte of the UART RX FIFO (show-ahead), valid while rx_empty=0.
REQ-006 SHALL have port rx_empty  input  1  RX FIFO empty flag.
REQ-007 SHALL have port rx_pop  output  1  pop strobe; a byte is consumed in the cycle where rx_pop=1 and rx_empty=0.
REQ-008 SHALL have port cmd_valid  output  1  one-cycle pulse: a recognised command line was received.
REQ-009 SHALL have port cmd_code  output  4  command code; held stable from the cmd_valid pulse until the next pulse.
REQ-010 SHALL have port cmd_err  output  1  one-cycle pulse: the line was unrecognised, empty or overlong.
REQ-011 SHALL have port busy  output  1  high while a line is partially received (length counter nonzero or DISCARD state).

Function
REQ-012 SHALL recognise these lines, each terminated by 0x0A, mapped to cmd_code:
- qstick=0, golden=1, sodapop=2, pause=3, restart=4, reset=5 (lowercase ASCII)
- BAD=6, GOOD=7, PERFECT=8 (uppercase ASCII)
REQ-013 SHALL ignore 0x0D entirely: it is consumed, it does not count toward length, and it is not compared.
REQ-014 SHALL drive rx_pop = ~rx_empty in every state except EMIT; rx_pop SHALL never be asserted while rx_empty=1.
REQ-015 SHALL use FSM states IDLE, COLLECT, DISCARD, EMIT.
- IDLE -> COLLECT on the first accepted non-terminator byte.
- COLLECT -> EMIT on accepted 0x0A.
- COLLECT -> DISCARD on an accepted character while length = MAX_LEN.
- DISCARD -> EMIT on accepted 0x0A.
- EMIT -> IDLE after exactly one cycle.
REQ-016 SHALL maintain a 9-bit candidate mask, set to all ones at line start; each accepted character at index i SHALL clear every candidate whose string length <= i or whose character at i differs.
REQ-017 SHALL report a match at terminator time only if exactly one candidate bit remains and that candidate's length equals the received length.
REQ-018 SHALL pulse either cmd_valid or cmd_err (never both) in the EMIT cycle, i.e. one cycle after the cycle in which 0x0A was accepted.
REQ-019 SHALL update cmd_code in the EMIT cycle only when cmd_valid=1; otherwise cmd_code holds its previous value.
REQ-020 SHALL treat 0x0A accepted in IDLE (empty line) as cmd_err and enter EMIT.
REQ-021 SHALL make the error in DISCARD sticky: the terminator produces cmd_err, and no characters are compared in that state.
REQ-022 SHALL start the next line cleanly after EMIT, with the mask reset and length set to 0.
REQ-023 SHALL use a length counter of $clog2(MAX_LEN+1) bits that saturates and never wraps.

Reset
REQ-024 SHALL, while reset=0 at a clock edge, set state to IDLE and drive rx_pop=0, cmd_valid=0, cmd_err=0, cmd_code=4'hF, busy=0, length=0, mask=all ones.
REQ-025 SHALL abandon a partial line when reset occurs mid-line: no pulse is issued, and the first byte after release starts a fresh line.

Structure
REQ-026 SHALL place the following in shared package uart_cmd_pkg, which the transmitter also uses:
- cmd_e enum (4-bit)
- CMD_NUM = 9
- CMD_MAXLEN = 8
- CMD_STR table (ASCII bytes per command)
- CMD_LEN table
- ASCII_LF and ASCII_CR constants
REQ-027 SHALL contain one sub-module, uart_cmd_rom: combinational (cmd index, char index) -> byte, plus a length lookup; the FSM and mask logic stay in uart_cmd_parser.

Verification
REQ-028 SHALL cover: feed "golden\n" back-to-back -> cmd_valid pulses once, 1 cycle after the LF pop, with cmd_code=1 and cmd_err=0.
REQ-029 SHALL cover: feed "reset\r\n", then "restart\n" -> cmd_code=5, then cmd_code=4; the prefix "res" is resolved only by length/terminator.
REQ-030 SHALL cover: feed "GOO\n", then "\n" -> two cmd_err pulses, and cmd_code stays at its prior value.
REQ-031 SHALL cover: feed "sodapopXX\n" (9 characters) -> DISCARD is entered at the 9th character, cmd_err pulses once after LF, and a following "pause\n" yields cmd_code=3.
REQ-032 SHALL cover: feed "PERFECT\n" with rx_empty toggling randomly -> the same single cmd_valid with cmd_code=8, and rx_pop is never high while rx_empty=1.
REQ-033 SHALL cover: assert reset=0 for one cycle after "qst" -> no pulse; "BAD\n" afterwards yields cmd_code=6.
